// File: rtl/child_dispatch_mailbox_pkg.sv
// rtl/child_dispatch_mailbox_pkg.sv - constants and state encoding shared by the mailbox dispatch/gather blocks
package child_dispatch_mailbox_pkg;

  typedef enum logic {
    ST_LOAD    = 1'b0,
    ST_DELIVER = 1'b1
  } state_e;

  localparam int NUM_CORES_DEFAULT = 31;
  localparam int DATA_W            = 32;
  localparam int ADDR_W_DEFAULT    = 5;

endpackage

// File: rtl/child_dispatch_mailbox_if.sv
// rtl/child_dispatch_mailbox_if.sv - parent write port, broadcast control and per-child mailbox lines
interface child_dispatch_mailbox_if #(
  parameter int NUM_CORES = child_dispatch_mailbox_pkg::NUM_CORES_DEFAULT,
  parameter int ADDR_W    = child_dispatch_mailbox_pkg::ADDR_W_DEFAULT
);
  import child_dispatch_mailbox_pkg::*;

  logic                        i_wr_en;
  logic [ADDR_W-1:0]           i_wr_core_addr;
  logic                        i_wr_sel;
  logic [DATA_W-1:0]           i_wr_data;
  logic                        i_go;
  logic                        o_busy;
  logic                        o_all_acked;
  logic                        o_wr_err;
  logic [NUM_CORES*DATA_W-1:0] o_mb_val_1;
  logic [NUM_CORES*DATA_W-1:0] o_mb_val_2;
  logic [NUM_CORES-1:0]        o_mb_valid;
  logic [NUM_CORES-1:0]        i_mb_ack;

  modport master (
    output i_wr_en, i_wr_core_addr, i_wr_sel, i_wr_data, i_go, i_mb_ack,
    input  o_busy, o_all_acked, o_wr_err, o_mb_val_1, o_mb_val_2, o_mb_valid
  );

  modport slave (
    input  i_wr_en, i_wr_core_addr, i_wr_sel, i_wr_data, i_go, i_mb_ack,
    output o_busy, o_all_acked, o_wr_err, o_mb_val_1, o_mb_val_2, o_mb_valid
  );

endinterface

// File: rtl/child_dispatch_mailbox_slot.sv
// rtl/child_dispatch_mailbox_slot.sv - one child's operand pair plus its valid/acked flags
module child_dispatch_mailbox_slot
  import child_dispatch_mailbox_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic              i_wr_sel,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_set_valid,
  input  logic              i_ack,
  output logic [DATA_W-1:0] o_val_1,
  output logic [DATA_W-1:0] o_val_2,
  output logic              o_valid,
  output logic              o_acked
);

  logic [DATA_W-1:0] r_val_1;
  logic [DATA_W-1:0] r_val_2;
  logic              r_valid;
  logic              r_acked;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_val_1 <= '0;
      r_val_2 <= '0;
      r_valid <= 1'b0;
      r_acked <= 1'b0;
    end else begin
      if (i_wr_en) begin
        if (i_wr_sel) r_val_2 <= i_wr_data;
        else          r_val_1 <= i_wr_data;
      end
      // An ack only counts against a slot that is currently offering work
      if (i_set_valid) begin
        r_valid <= 1'b1;
        r_acked <= 1'b0;
      end else if (i_ack && r_valid) begin
        r_valid <= 1'b0;
        r_acked <= 1'b1;
      end
    end
  end

  assign o_val_1 = r_val_1;
  assign o_val_2 = r_val_2;
  assign o_valid = r_valid;
  assign o_acked = r_acked;

endmodule

// File: rtl/child_dispatch_mailbox.sv
// rtl/child_dispatch_mailbox.sv - parent-to-child operand dispatch with broadcast go and all-acked gather
module child_dispatch_mailbox
  import child_dispatch_mailbox_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  child_dispatch_mailbox_if.slave mb
);

  localparam logic [ADDR_W:0] LP_NUM_SLOTS = (ADDR_W+1)'(NUM_CORES);

  state_e                      r_state;
  state_e                      w_state_next;
  logic                        r_all_acked;
  logic                        r_wr_err;
  logic                        w_addr_in_range;
  logic                        w_wr_ok;
  logic                        w_wr_bad;
  logic                        w_go;
  logic                        w_done;
  logic [NUM_CORES-1:0]        w_slot_we;
  logic [NUM_CORES-1:0]        w_valid;
  logic [NUM_CORES-1:0]        w_acked;
  logic [NUM_CORES-1:0]        w_acked_next;
  wire  [NUM_CORES*DATA_W-1:0] w_val_1_flat;
  wire  [NUM_CORES*DATA_W-1:0] w_val_2_flat;

  assign w_addr_in_range = ({1'b0, mb.i_wr_core_addr} < LP_NUM_SLOTS);
  // Acks sampled this cycle count toward completion so the round ends one cycle after the last ack
  assign w_acked_next    = w_acked | (mb.i_mb_ack & w_valid);
  assign w_wr_bad        = mb.i_wr_en && !w_wr_ok;

  always_comb begin
    w_state_next = r_state;
    w_wr_ok      = 1'b0;
    w_go         = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_wr_ok = mb.i_wr_en && w_addr_in_range;
        if (mb.i_go) begin
          w_go         = 1'b1;
          w_state_next = ST_DELIVER;
        end
      end
      ST_DELIVER: begin
        if (&w_acked_next) begin
          w_done       = 1'b1;
          w_state_next = ST_LOAD;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_LOAD;
      r_all_acked <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_wr_err <= w_wr_bad;
      if (w_done)               r_all_acked <= 1'b1;
      else if (w_go || w_wr_ok) r_all_acked <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
    localparam logic [ADDR_W-1:0] LP_IDX = ADDR_W'(gi);

    assign w_slot_we[gi] = w_wr_ok && (mb.i_wr_core_addr == LP_IDX);

    child_dispatch_mailbox_slot u_slot (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr_en     (w_slot_we[gi]),
      .i_wr_sel    (mb.i_wr_sel),
      .i_wr_data   (mb.i_wr_data),
      .i_set_valid (w_go),
      .i_ack       (mb.i_mb_ack[gi]),
      .o_val_1     (w_val_1_flat[gi*DATA_W +: DATA_W]),
      .o_val_2     (w_val_2_flat[gi*DATA_W +: DATA_W]),
      .o_valid     (w_valid[gi]),
      .o_acked     (w_acked[gi])
    );
  end

  assign mb.o_busy      = (r_state == ST_DELIVER);
  assign mb.o_all_acked = r_all_acked;
  assign mb.o_wr_err    = r_wr_err;
  assign mb.o_mb_valid  = w_valid;
  assign mb.o_mb_val_1  = w_val_1_flat;
  assign mb.o_mb_val_2  = w_val_2_flat;

endmodule

// File: doc/child_dispatch_mailbox.md
Name: child_dispatch_mailbox

Overview:
- Parent-to-child direction of the multicore mailbox interface; the complement of the child-to-parent result/flag gather path.
- The parent core writes per-child operand pairs (val_1, val_2) into mailbox slots, then issues one broadcast "go".
- Every child sees its slot marked valid and acknowledges consumption.
- The parent observes all_acked to know that every child has picked up its work.

Parameters:
- NUM_CORES, 31, number of child cores/slots.
- DATA_W, 32, operand width.
- ADDR_W, 5, slot address width; must satisfy 2^ADDR_W >= NUM_CORES.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- wr_en  in  1  parent slot write strobe.
- wr_core_addr  in  ADDR_W  target slot index.
- wr_sel  in  1  selects the operand: 0 = val_1, 1 = val_2.
- wr_data  in  DATA_W  operand data.
- go  in  1  parent broadcast-release pulse.
- busy  out  1  high while a dispatch round is outstanding.
- all_acked  out  1  high once every slot has acknowledged the last round.
- wr_err  out  1  one-cycle pulse when a write is rejected.
- mb_val_1  out  NUM_CORES*DATA_W  flattened per-child operand 1; slot i occupies bits [i*DATA_W +: DATA_W].
- mb_val_2  out  NUM_CORES*DATA_W  flattened per-child operand 2.
- mb_valid  out  NUM_CORES  per-child "work available" flag.
- mb_ack  in  NUM_CORES  per-child consume acknowledge; level-sampled each cycle.

Behaviour:
- Reset values (Reset high at a rising Clk edge):
  - all slot registers = 0, mb_valid = 0, acked vector = 0.
  - busy = 0, all_acked = 0, wr_err = 0.
  - state = LOAD.
  - Reset asserted mid-round aborts the round; no valid flag survives.
- FSM has two states: LOAD and DELIVER.
- LOAD:
  - wr_en with wr_core_addr < NUM_CORES writes wr_data into the slot/operand chosen by wr_sel at the edge.
  - The data is visible on mb_val_* in the next cycle.
  - wr_en with wr_core_addr >= NUM_CORES: no write; wr_err = 1 for the next cycle.
  - Any accepted write clears all_acked.
  - go: transition to DELIVER. On the next cycle mb_valid = all ones, busy = 1, all_acked = 0, and the acked vector is cleared.
- Simultaneous wr_en and go in LOAD: the write is committed in the same edge and is part of the round being released.
- DELIVER:
  - wr_en is rejected: no write, wr_err pulses. Slot contents stay stable while mb_valid is high.
  - go is ignored.
  - mb_ack[i] = 1 while mb_valid[i] = 1: mb_valid[i] = 0 and acked[i] = 1 from the next cycle.
  - mb_ack[i] while mb_valid[i] = 0: ignored.
  - Multiple children may acknowledge in the same cycle; each is handled independently.
  - When the acked vector (including acks sampled this cycle) becomes all ones: return to LOAD next cycle with busy = 0 and all_acked = 1.
- Latency:
  - go sampled at cycle N: mb_valid is all ones at N+1.
  - Last ack sampled at cycle M: busy = 0 and all_acked = 1 at M+1.
  - Minimum round length is 2 cycles (go, then all acks together).
- all_acked stays high in LOAD until the next accepted write or go.
- Slot data is never cleared by an ack. Unwritten slots are re-broadcast with their previous values.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding (LOAD = 1'b0, DELIVER = 1'b1);
  - NUM_CORES_DEFAULT = 31 and DATA_W = 32, so the gather side and this block use identical constants.
- One natural sub-module: mailbox_slot.
  - Contains val_1/val_2 registers plus the valid and acked flags.
  - Inputs: per-slot write enable, operand select, set-valid (from go), ack.
  - Instantiated NUM_CORES times by generate.
  - The top level keeps the FSM, address decode, error pulse and the all-ones reduction.

Test Plan:
- Reset, then write slot 0 val_1 = 0x11, val_2 = 0x22, and slot 30 val_1 = 0xDEADBEEF; pulse go -> mb_valid = 0x7FFFFFFF and busy = 1 one cycle later; the mb_val_* fields hold the exact written values.
- After go, ack cores 0..29 one per cycle, then core 30 -> each valid bit drops one cycle after its ack; all_acked = 1 and busy = 0 exactly one cycle after core 30's ack.
- Write with wr_core_addr = 31 in LOAD, and wr_core_addr = 3 during DELIVER -> wr_err pulses one cycle each time; slot 3 data is unchanged.
- Same-cycle wr_en (slot 5, val_2 = 0x55) and go -> the round is released with slot 5 val_2 = 0x55; all mb_ack held high the next cycle -> all_acked = 1 two cycles after go.
- Ack core 7 while it is not valid (in LOAD, and again after it has already acked) -> no state change; all_acked is not asserted early.
- Assert Reset mid-DELIVER with 10 cores acked -> next cycle mb_valid = 0, busy = 0, all_acked = 0, all slots = 0, and a fresh write/go sequence works.
